// File: rtl/afifo_lvl_if.sv
// Handshake bundle for afifo_lvl.
//  master: drives wr_en/wdata/wr_ovf_clr (producer) and rd_en/rd_udf_clr (consumer)
//  slave : the FIFO; returns flags, levels, sticky errors and rdata
`timescale 1ns/100ps
interface afifo_lvl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wr_full;
  logic                  wr_afull;
  logic [ADDR_WIDTH:0]   wr_level;
  logic                  wr_ovf;
  logic                  wr_ovf_clr;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rd_empty;
  logic                  rd_aempty;
  logic [ADDR_WIDTH:0]   rd_level;
  logic                  rd_udf;
  logic                  rd_udf_clr;

  modport master (
    output wr_en, wdata, wr_ovf_clr, rd_en, rd_udf_clr,
    input  wr_full, wr_afull, wr_level, wr_ovf,
    input  rdata, rd_empty, rd_aempty, rd_level, rd_udf
  );
  modport slave (
    input  wr_en, wdata, wr_ovf_clr, rd_en, rd_udf_clr,
    output wr_full, wr_afull, wr_level, wr_ovf,
    output rdata, rd_empty, rd_aempty, rd_level, rd_udf
  );
endinterface

// File: rtl/afifo_lvl.sv
// afifo_lvl: dual-clock FIFO, Gray-pointer CDC, depth 2**ADDR_WIDTH.
//  Per-side registered fill levels, almost-full/almost-empty, sticky ovf/udf,
//  optional first-word-fall-through read port.
// Ports:
//  clk_wr/rst_wr_n  write clock, async active-low write-domain reset
//  clk_rd/rst_rd_n  read clock, async active-low read-domain reset
//  bus (slave)      wr_en/wdata/wr_full/wr_afull/wr_level/wr_ovf/wr_ovf_clr,
//                   rd_en/rdata/rd_empty/rd_aempty/rd_level/rd_udf/rd_udf_clr
`timescale 1ns/100ps

// Gray-pointer synchroniser chain, reset by the destination domain.
module afifo_lvl_sync #(
  parameter int W      = 4,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [STAGES-1:0][W-1:0] sr;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sr <= '0;
    else        sr <= {sr[STAGES-2:0], d};

  assign q = sr[STAGES-1];
endmodule

module afifo_lvl #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 3,
  parameter int SYNC_STAGES = 2,
  parameter int AFULL_TH    = 6,
  parameter int AEMPTY_TH   = 2,
  parameter int FWFT        = 0
) (
  input  logic         clk_wr,
  input  logic         rst_wr_n,
  input  logic         clk_rd,
  input  logic         rst_rd_n,
  afifo_lvl_if.slave   bus
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AFL = PW'(AFULL_TH);
  localparam logic [PW-1:0] AEL = PW'(AEMPTY_TH);

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // ---------------- write domain ----------------
  logic          wr_acc;
  logic [PW-1:0] wbin, wgray, wbin_nxt, wgray_nxt, rgray_s, rbin_s;

  assign wr_acc    = bus.wr_en & ~bus.wr_full;
  assign wbin_nxt  = wbin + PW'(wr_acc);
  assign wgray_nxt = bin2gray(wbin_nxt);
  assign rbin_s    = gray2bin(rgray_s);

  always_ff @(posedge clk_wr)
    if (wr_acc) mem[wbin[ADDR_WIDTH-1:0]] <= bus.wdata;

  // Flags use the post-write pointer so full asserts on the filling edge.
  // The synced read pointer lags, so full/level only ever err towards fuller.
  always_ff @(posedge clk_wr or negedge rst_wr_n)
    if (!rst_wr_n) begin
      wbin         <= '0;
      wgray        <= '0;
      bus.wr_full  <= 1'b0;
      bus.wr_level <= '0;
      bus.wr_afull <= 1'b0;
      bus.wr_ovf   <= 1'b0;
    end else begin
      wbin         <= wbin_nxt;
      wgray        <= wgray_nxt;
      bus.wr_full  <= wgray_nxt == {~rgray_s[PW-1:PW-2], rgray_s[PW-3:0]};
      bus.wr_level <= wbin_nxt - rbin_s;
      bus.wr_afull <= bus.wr_level >= AFL;
      bus.wr_ovf   <= (bus.wr_en & bus.wr_full) | (bus.wr_ovf & ~bus.wr_ovf_clr);
    end

  // ---------------- read domain ----------------
  logic          rd_acc, empty_nxt;
  logic [PW-1:0] rbin, rgray, rbin_nxt, rgray_nxt, wgray_s, wbin_s;

  assign rd_acc    = bus.rd_en & ~bus.rd_empty;
  assign rbin_nxt  = rbin + PW'(rd_acc);
  assign rgray_nxt = bin2gray(rbin_nxt);
  assign wbin_s    = gray2bin(wgray_s);
  assign empty_nxt = rgray_nxt == wgray_s;

  always_ff @(posedge clk_rd or negedge rst_rd_n)
    if (!rst_rd_n) begin
      rbin          <= '0;
      rgray         <= '0;
      bus.rd_empty  <= 1'b1;
      bus.rd_level  <= '0;
      bus.rd_aempty <= 1'b1;
      bus.rd_udf    <= 1'b0;
      bus.rdata     <= '0;
    end else begin
      rbin          <= rbin_nxt;
      rgray         <= rgray_nxt;
      bus.rd_empty  <= empty_nxt;
      bus.rd_level  <= wbin_s - rbin_nxt;
      bus.rd_aempty <= bus.rd_level <= AEL;
      bus.rd_udf    <= (bus.rd_en & bus.rd_empty) | (bus.rd_udf & ~bus.rd_udf_clr);
      // FWFT preloads the head whenever the next state is non-empty; the
      // entry is already stable since its pointer crossed the synchroniser.
      if (FWFT != 0) begin
        if (!empty_nxt) bus.rdata <= mem[rbin_nxt[ADDR_WIDTH-1:0]];
      end else if (rd_acc) begin
        bus.rdata <= mem[rbin[ADDR_WIDTH-1:0]];
      end
    end

  // ---------------- pointer crossings ----------------
  afifo_lvl_sync #(.W(PW), .STAGES(SYNC_STAGES)) u_sync_w2r (
    .clk(clk_rd), .rst_n(rst_rd_n), .d(wgray), .q(wgray_s)
  );
  afifo_lvl_sync #(.W(PW), .STAGES(SYNC_STAGES)) u_sync_r2w (
    .clk(clk_wr), .rst_n(rst_wr_n), .d(rgray), .q(rgray_s)
  );
endmodule

// File: tb/tb_afifo_lvl.sv
// Directed + scoreboarded random bench for afifo_lvl (FWFT=0 and FWFT=1 instances).
`timescale 1ns/100ps
module tb_afifo_lvl;
  localparam int DW = 32;
  localparam int AW = 3;
  localparam int N  = 2000;

  logic clk_wr = 1'b0, clk_rd = 1'b0;
  logic rst_wr_n = 1'b0, rst_rd_n = 1'b0;

  always #5    clk_wr = ~clk_wr;
  always #13.5 clk_rd = ~clk_rd;

  afifo_lvl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b0 ();
  afifo_lvl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b1 ();

  afifo_lvl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SYNC_STAGES(2),
              .AFULL_TH(6), .AEMPTY_TH(2), .FWFT(0)) u0 (
    .clk_wr(clk_wr), .rst_wr_n(rst_wr_n), .clk_rd(clk_rd), .rst_rd_n(rst_rd_n), .bus(b0)
  );
  afifo_lvl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SYNC_STAGES(2),
              .AFULL_TH(6), .AEMPTY_TH(2), .FWFT(1)) u1 (
    .clk_wr(clk_wr), .rst_wr_n(rst_wr_n), .clk_rd(clk_rd), .rst_rd_n(rst_rd_n), .bus(b1)
  );

  int errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic push0(input logic [DW-1:0] d);
    b0.wr_en = 1'b1; b0.wdata = d;
    @(posedge clk_wr); #1;
    b0.wr_en = 1'b0;
  endtask

  task automatic push1(input logic [DW-1:0] d);
    b1.wr_en = 1'b1; b1.wdata = d;
    @(posedge clk_wr); #1;
    b1.wr_en = 1'b0;
  endtask

  task automatic pop0();
    b0.rd_en = 1'b1;
    @(posedge clk_rd); #1;
    b0.rd_en = 1'b0;
  endtask

  task automatic pop1();
    b1.rd_en = 1'b1;
    @(posedge clk_rd); #1;
    b1.rd_en = 1'b0;
  endtask

  logic [DW-1:0] q [$];
  int rx = 0, flag_err = 0, n0, n1, nw;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    b0.wr_en = 0; b0.wdata = '0; b0.wr_ovf_clr = 0; b0.rd_en = 0; b0.rd_udf_clr = 0;
    b1.wr_en = 0; b1.wdata = '0; b1.wr_ovf_clr = 0; b1.rd_en = 0; b1.rd_udf_clr = 0;

    // reset
    repeat (4) @(posedge clk_rd); #1;
    chk("rst_empty_in", b0.rd_empty, 1);
    chk("rst_full_in",  b0.wr_full,  0);
    rst_wr_n = 1'b1; rst_rd_n = 1'b1;
    repeat (3) @(posedge clk_rd); #1;
    chk("rst_empty",  b0.rd_empty,  1);
    chk("rst_full",   b0.wr_full,   0);
    chk("rst_wlvl",   b0.wr_level,  0);
    chk("rst_rlvl",   b0.rd_level,  0);
    chk("rst_aempty", b0.rd_aempty, 1);
    chk("rst_afull",  b0.wr_afull,  0);
    chk("rst_rdata",  b0.rdata,     0);
    chk("rst_ovf",    b0.wr_ovf,    0);
    chk("rst_udf",    b0.rd_udf,    0);
    chk("rst_rdata1", b1.rdata,     0);
    chk("rst_empty1", b1.rd_empty,  1);

    // fill 8 deep, no reads
    @(posedge clk_wr); #1;
    for (int i = 0; i < 8; i++) begin
      push0(32'h100 + i);
      chk("fill_lvl",   b0.wr_level, i + 1);
      chk("fill_full",  b0.wr_full,  i == 7);
      chk("fill_afull", b0.wr_afull, i >= 6);
    end

    // overflow and sticky clear
    push0(32'hDEAD);
    chk("ovf_set",  b0.wr_ovf,   1);
    chk("ovf_lvl",  b0.wr_level, 8);
    chk("ovf_full", b0.wr_full,  1);
    b0.wr_ovf_clr = 1; @(posedge clk_wr); #1; b0.wr_ovf_clr = 0;
    chk("ovf_clr", b0.wr_ovf, 0);
    b0.wr_ovf_clr = 1; b0.wr_en = 1; b0.wdata = 32'hBEEF;
    @(posedge clk_wr); #1;
    b0.wr_ovf_clr = 0; b0.wr_en = 0;
    chk("ovf_setwins", b0.wr_ovf, 1);
    b0.wr_ovf_clr = 1; @(posedge clk_wr); #1; b0.wr_ovf_clr = 0;
    chk("ovf_clr2", b0.wr_ovf, 0);

    // drain
    repeat (4) @(posedge clk_rd); #1;
    chk("rd_lvl8",   b0.rd_level,  8);
    chk("rd_ne",     b0.rd_empty,  0);
    chk("rd_naemp",  b0.rd_aempty, 0);
    for (int i = 0; i < 8; i++) begin
      pop0();
      chk("drain_data",  b0.rdata,     32'h100 + i);
      chk("drain_lvl",   b0.rd_level,  7 - i);
      chk("drain_empty", b0.rd_empty,  i == 7);
      chk("drain_aemp",  b0.rd_aempty, i >= 6);
    end
    nw = 0;
    while (b0.wr_full && nw < 20) begin @(posedge clk_wr); #1; nw++; end
    chk("full_release", b0.wr_full, 0);
    repeat (5) @(posedge clk_wr); #1;
    chk("wlvl_zero",  b0.wr_level, 0);
    chk("afull_zero", b0.wr_afull, 0);

    // underflow
    pop0();
    chk("udf_set",   b0.rd_udf,   1);
    chk("udf_rdata", b0.rdata,    32'h107);
    chk("udf_lvl",   b0.rd_level, 0);
    chk("udf_empty", b0.rd_empty, 1);
    b0.rd_udf_clr = 1; @(posedge clk_rd); #1; b0.rd_udf_clr = 0;
    chk("udf_clr", b0.rd_udf, 0);

    // write-to-empty latency, both read modes
    @(posedge clk_wr); #1;
    b0.wr_en = 1; b0.wdata = 32'hA5; b1.wr_en = 1; b1.wdata = 32'hA5;
    @(posedge clk_wr); #0.2;
    b0.wr_en = 0; b1.wr_en = 0;
    n0 = 0; n1 = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk_rd); #1;
      if (n0 == 0 && !b0.rd_empty) n0 = k;
      if (n1 == 0 && !b1.rd_empty) begin
        n1 = k;
        chk("fwft_a5", b1.rdata, 32'hA5);
      end
      if (n0 != 0 && n1 != 0) break;
    end
    chk("lat_reg",  n0, 3);
    chk("lat_fwft", n1, 3);
    chk("reg_hold", b0.rdata, 32'h107);
    pop0();
    chk("reg_a5", b0.rdata, 32'hA5);

    // FWFT pops
    pop1();
    chk("fwft_empty", b1.rd_empty, 1);
    chk("fwft_hold",  b1.rdata,    32'hA5);
    push1(32'h11);
    push1(32'h22);
    repeat (6) @(posedge clk_rd); #1;
    chk("fwft_head", b1.rdata,    32'h11);
    chk("fwft_lvl",  b1.rd_level, 2);
    pop1();
    chk("fwft_next", b1.rdata,    32'h22);
    chk("fwft_ne",   b1.rd_empty, 0);
    pop1();
    chk("fwft_last", b1.rdata,    32'h22);
    chk("fwft_emp2", b1.rd_empty, 1);

    // random streaming, scoreboard
    fork
      begin : writer
        int sent;
        sent = 0;
        for (int c = 0; c < 60000 && sent < N; c++) begin
          @(posedge clk_wr); #1;
          b0.wr_en = 1'b0;
          if (!b0.wr_full && $urandom_range(0, 3) != 0) begin
            b0.wr_en = 1'b1;
            b0.wdata = $urandom;
            q.push_back(b0.wdata);
            sent++;
          end
        end
        @(posedge clk_wr); #1;
        b0.wr_en = 1'b0;
      end
      begin : reader
        logic pend;
        logic [DW-1:0] e;
        pend = 1'b0;
        for (int c = 0; c < 30000 && rx < N; c++) begin
          @(posedge clk_rd); #1;
          if (pend) begin
            if (q.size() == 0) flag_err++;
            else begin
              e = q.pop_front();
              chk("rnd_data", b0.rdata, e);
            end
            rx++;
          end
          if (!b0.rd_empty && q.size() == 0) flag_err++;
          if (int'(b0.rd_level) > q.size()) flag_err++;
          b0.rd_en = 1'b0;
          pend = 1'b0;
          if (!b0.rd_empty && $urandom_range(0, 2) != 0) begin
            b0.rd_en = 1'b1;
            pend = 1'b1;
          end
        end
        b0.rd_en = 1'b0;
      end
    join
    repeat (6) @(posedge clk_rd); #1;
    chk("rnd_count",  rx,         N);
    chk("rnd_left",   q.size(),   0);
    chk("rnd_flags",  flag_err,   0);
    chk("rnd_ovf",    b0.wr_ovf,  0);
    chk("rnd_udf",    b0.rd_udf,  0);
    chk("rnd_empty",  b0.rd_empty, 1);
    chk("rnd_wlvl",   b0.wr_level, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
